// File: rtl/reg_file_pkg.sv
// Shared definitions for the multi-port integer register file: sweep states
// and the depth helper that sizes storage and the scoreboard.
package reg_file_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_e;

    localparam int MAX_READ_PORTS = 4;

    function automatic int rf_depth(input int address_width);
        return 1 << address_width;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-producer scoreboard: one bit per register, set by a reservation,
// cleared by the landing write, plus the per-port busy lookup.
module reg_scoreboard
    import reg_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int READ_PORTS    = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                ready,
    input  logic                                we,
    input  logic [ADDRESS_WIDTH-1:0]            wr_addr,
    input  logic                                rsv_en,
    input  logic [ADDRESS_WIDTH-1:0]            rsv_addr,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS-1:0]               rd_busy
);

    localparam int DEPTH = rf_depth(ADDRESS_WIDTH);

    logic [DEPTH-1:0] pending_q;
    logic             wr_clr;
    logic             rsv_set;

    assign wr_clr  = ready && we && (wr_addr != '0);
    assign rsv_set = ready && rsv_en && (rsv_addr != '0);

    // The reservation is applied last so a newer producer outlives the
    // write that retires the older one to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            if (wr_clr) begin
                pending_q[wr_addr] <= 1'b0;
            end
            if (rsv_set) begin
                pending_q[rsv_addr] <= 1'b1;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_busy
        logic [ADDRESS_WIDTH-1:0] addr;
        assign addr       = rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rd_busy[p] = pending_q[addr]
                            && !(we && (wr_addr == addr))
                            && (addr != '0);
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write-to-read bypass, pending
// scoreboard and a post-reset sweep that zeroes storage before ready.
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int READ_PORTS    = 2,
    parameter int DEBUG_REG     = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                we,
    input  logic [ADDRESS_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]               wr_data,
    input  logic [READ_PORTS*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [READ_PORTS*DATA_WIDTH-1:0]    rd_data,
    output logic [READ_PORTS-1:0]               rd_busy,
    input  logic                                rsv_en,
    input  logic [ADDRESS_WIDTH-1:0]            rsv_addr,
    output logic                                ready,
    output logic [DATA_WIDTH-1:0]               a0
);

    localparam int                       DEPTH   = rf_depth(ADDRESS_WIDTH);
    localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DEBUG_REG);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t                    regs [DEPTH];
    rf_state_e                state_q;
    rf_state_e                state_d;
    logic [ADDRESS_WIDTH-1:0] idx_q;
    logic [ADDRESS_WIDTH-1:0] idx_d;
    logic                     wr_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            CLEAR: begin
                idx_d = idx_q + ADDRESS_WIDTH'(1);
                if (&idx_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                state_d = READY;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    assign ready   = (state_q == READY);
    assign wr_fire = ready && we && (wr_addr != '0);

    // Storage has no reset of its own; the sweep zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == CLEAR) begin
                regs[idx_q] <= '0;
            end else if (wr_fire) begin
                regs[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] addr;
        assign addr = rd_addr[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] =
            (!ready || (addr == '0))     ? '0      :
            (we && (wr_addr == addr))    ? wr_data :
                                           regs[addr];
    end

    assign a0 = ready ? regs[DBG_IDX] : '0;

    reg_scoreboard #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .READ_PORTS    (READ_PORTS)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .ready    (ready),
        .we       (we),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed and randomized bench for reg_file_mp with four read ports,
// checked every cycle against a behavioural register-file model.
module tb_reg_file_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int RP    = 4;
    localparam int DEPTH = 1 << AW;
    localparam int DBG   = 10;

    logic             clk;
    logic             rst;
    logic             we;
    logic [AW-1:0]    wr_addr;
    logic [DW-1:0]    wr_data;
    logic [RP*AW-1:0] rd_addr;
    logic [RP*DW-1:0] rd_data;
    logic [RP-1:0]    rd_busy;
    logic             rsv_en;
    logic [AW-1:0]    rsv_addr;
    logic             ready;
    logic [DW-1:0]    a0;

    reg_file_mp #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .READ_PORTS    (RP),
        .DEBUG_REG     (DBG)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .ready    (ready),
        .a0       (a0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, outstanding producers, sweep countdown.
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_pend [DEPTH];
    bit            m_ready;
    int            m_left;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] port_addr(input int p);
        return rd_addr[p*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] exp_data(input int p);
        logic [AW-1:0] a;
        a = port_addr(p);
        if (!m_ready || a == 0) return '0;
        if (we && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int p);
        logic [AW-1:0] a;
        a = port_addr(p);
        return m_ready && m_pend[a] && !(we && wr_addr == a) && (a != 0);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_left  = DEPTH;
            foreach (m_pend[i]) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_left--;
            if (m_left == 0) begin
                m_ready = 1'b1;
                foreach (m_regs[i]) m_regs[i] = '0;
            end
        end else begin
            if (we && wr_addr != 0) begin
                m_regs[wr_addr] = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
        end
    endtask

    // Inputs are stable from posedge+1; outputs checked at the falling edge.
    task automatic cycle();
        #4;
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        chk("a0", a0, m_ready ? m_regs[DBG] : '0);
        for (int p = 0; p < RP; p++) begin
            chk($sformatf("rd_data[%0d]@%0d", p, port_addr(p)), rd_data[p*DW +: DW], exp_data(p));
            chk($sformatf("rd_busy[%0d]@%0d", p, port_addr(p)), {31'b0, rd_busy[p]}, {31'b0, exp_busy(p)});
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
        return AW'($urandom_range(0, 7));
    endfunction

    task automatic drive_rand();
        we       = 1'($urandom_range(0, 1));
        wr_addr  = rand_addr();
        wr_data  = $urandom;
        rsv_en   = ($urandom_range(0, 2) == 0);
        rsv_addr = rand_addr();
        for (int p = 0; p < RP; p++) rd_addr[p*AW +: AW] = rand_addr();
    endtask

    task automatic idle();
        we = 1'b0; wr_addr = '0; wr_data = '0; rsv_en = 1'b0; rsv_addr = '0;
    endtask

    task automatic all_ports(input logic [AW-1:0] a);
        for (int p = 0; p < RP; p++) rd_addr[p*AW +: AW] = a;
    endtask

    task automatic sweep_and_count(input string tag);
        int cnt;
        cnt = 0;
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 8 && ready !== 1'b1; i++) begin
            drive_rand();
            cycle();
            cnt++;
        end
        chk(tag, cnt, DEPTH);
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd_addr = '0;
        foreach (m_regs[i]) m_regs[i] = '0;
        @(posedge clk);
        @(posedge clk);
        model_edge();
        #1;
        drive_rand();
        cycle();
        sweep_and_count("sweep_len_first");

        // write with same-cycle bypass, then stored value
        idle();
        we = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF;
        all_ports(5);
        cycle();
        chk("bypass_deadbeef", rd_data[0 +: DW], 32'hDEADBEEF);
        idle();
        cycle();
        chk("stored_deadbeef", rd_data[0 +: DW], 32'hDEADBEEF);

        // x0: writes and reservations dropped
        we = 1'b1; wr_addr = 0; wr_data = 32'h1234; rsv_en = 1'b1; rsv_addr = 0;
        all_ports(0);
        cycle();
        idle();
        cycle();
        chk("x0_data", rd_data[DW +: DW], '0);
        chk("x0_busy", {28'b0, rd_busy}, '0);

        // scoreboard: reserve 7, write 7 clears in the write cycle
        rsv_en = 1'b1; rsv_addr = 7;
        all_ports(7);
        cycle();
        idle();
        cycle();
        chk("busy_after_rsv7", {31'b0, rd_busy[1]}, 32'd1);
        we = 1'b1; wr_addr = 7; wr_data = 32'hA5A5_0007;
        #1;
        chk("busy_clear_in_write", {31'b0, rd_busy[1]}, 32'd0);
        cycle();

        // reserve and write index 9 together: reservation wins
        idle();
        we = 1'b1; wr_addr = 9; wr_data = 32'h0000_0999; rsv_en = 1'b1; rsv_addr = 9;
        all_ports(9);
        cycle();
        idle();
        cycle();
        chk("rsv_wins_busy", {31'b0, rd_busy[1]}, 32'd1);
        chk("rsv_wins_data", rd_data[DW +: DW], 32'h0000_0999);

        // a0: old value in the write cycle, new value afterwards
        we = 1'b1; wr_addr = DBG; wr_data = 32'h55;
        all_ports(AW'(DBG));
        cycle();
        idle();
        cycle();
        chk("a0_after_write", a0, 32'h55);
        for (int p = 0; p < RP; p++) chk($sformatf("port%0d_reg10", p), rd_data[p*DW +: DW], 32'h55);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive_rand();
            cycle();
        end

        // mid-sweep reset at index 12, writes during sweep ignored
        idle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            drive_rand();
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        sweep_and_count("sweep_len_midreset");

        // garbage, single-cycle reset, then every index reads 0
        for (int i = 0; i < 60; i++) begin
            drive_rand();
            we = 1'b1;
            cycle();
        end
        idle();
        rst = 1'b1;
        cycle();
        sweep_and_count("sweep_len_final");
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            all_ports(AW'(a));
            cycle();
            chk($sformatf("cleared_%0d", a), rd_data[(RP-1)*DW +: DW], '0);
        end

        for (int i = 0; i < 200; i++) begin
            drive_rand();
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port integer register file for the pipelined RISC-V core, successor to the single-issue two-read-port file. It adds:
- configurable read-port count;
- same-cycle write-to-read bypass;
- a per-register pending scoreboard for hazard detection;
- a post-reset clear sweep that zeroes every register before the file reports ready.

It sits between decode (reads, reservations) and writeback (writes).

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register index width; depth = 2^ADDRESS_WIDTH
- DATA_WIDTH, 32, register width
- READ_PORTS, 2, number of independent read ports (1..4)
- DEBUG_REG, 10, index exported on a0

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- we  in  1  write enable (writeback)
- wr_addr  in  ADDRESS_WIDTH  write index
- wr_data  in  DATA_WIDTH  write data
- rd_addr  in  READ_PORTS×ADDRESS_WIDTH  packed read indices, port i at slice i
- rd_data  out  READ_PORTS×DATA_WIDTH  packed read data
- rd_busy  out  READ_PORTS  register addressed by port i has an outstanding producer
- rsv_en  in  1  reserve a destination (decode issues a producing instruction)
- rsv_addr  in  ADDRESS_WIDTH  index to reserve
- ready  out  1  clear sweep finished; file accepts writes and reservations
- a0  out  DATA_WIDTH  contents of register DEBUG_REG

## Operation
- States: CLEAR and READY.
  - rst high: state <= CLEAR, sweep index <= 0, all pending bits <= 0.
  - In CLEAR with rst low, each cycle does regs[idx] <= 0 and idx <= idx+1.
  - After the write to index 2^ADDRESS_WIDTH−1, state <= READY.
- A reset asserted mid-sweep or in READY restarts the sweep at index 0.
- Writes and reservations are ignored while ready=0.
- Register 0 reads 0 always; writes to it and reservations of it are dropped.
- Write: in READY, we && wr_addr!=0 → regs[wr_addr] <= wr_data and pending[wr_addr] <= 0.
- Read (per port, combinational):
  - ready=0 → 0.
  - Else rd_addr=0 → 0.
  - Else a write is landing (we && wr_addr==rd_addr) → wr_data (bypass).
  - Else regs[rd_addr].
- Scoreboard: in READY, rsv_en && rsv_addr!=0 → pending[rsv_addr] <= 1.
  - Reserve and write to the same index in one cycle: reserve wins, bit ends 1 (a newer producer is in flight).
- rd_busy[i] = pending[rd_addr[i]] && !(we && wr_addr==rd_addr[i]) && rd_addr[i]!=0. The landing write clears the hazard combinationally.
- Multiple read ports with the same index return identical data and busy.
- a0 = regs[DEBUG_REG], not bypassed; 0 while ready=0.

## Timing
- Reset values: ready=0, rd_busy=0, rd_data=0, a0=0.
- Sweep latency: rst sampled low at edge E0 → ready=1 after edge E0+2^ADDRESS_WIDTH−1. That is 32 clean cycles with default parameters.
- Read latency: 0 cycles (combinational from rd_addr, we, wr_addr, wr_data).
- Write latency: stored at the rising edge where we=1. Visible via bypass in the same cycle, via storage from the next cycle.
- Reservation: pending visible on rd_busy from the cycle after rsv_en.
- No handshake back-pressure; upstream must hold off until ready=1.

## Structure
- Shared package reg_file_pkg:
  - state enum (CLEAR, READY);
  - localparam for depth;
  - packed port-array typedefs, parametrised via the module parameters.
- One sub-module, reg_scoreboard:
  - owns the pending vector, reserve/clear logic and the per-port busy computation;
  - instantiated once.
- Storage, sweep FSM, bypass muxes and a0 tap live in reg_file_mp.

## Test plan
- Reset then sweep:
  - pre-load garbage via writes, pulse rst 1 cycle;
  - ready=0 for exactly 32 cycles, then 1;
  - every index reads 0.
- Write/bypass:
  - we=1, wr_addr=5, wr_data=0xDEADBEEF with rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF that cycle;
  - next cycle, with we=0, still 0xDEADBEEF.
- x0:
  - write 0x1234 to index 0 and rsv_en to index 0;
  - rd_data=0 and rd_busy=0 on all ports.
- Scoreboard:
  - rsv index 7 → rd_busy[1]=1 next cycle;
  - write index 7 → rd_busy[1]=0 in the write cycle;
  - simultaneous rsv+write to index 9 → rd_busy=1 afterwards and data updated.
- Mid-sweep reset:
  - reassert rst at sweep index 12;
  - ready stays 0 for 32 further cycles;
  - writes during sweep are ignored (read back 0).
- a0:
  - write 0x55 to index 10 → a0=0x55 next cycle, not in the write cycle;
  - with READY_PORTS=4, all four ports read index 10 → all return 0x55.
